// File: rtl/rv_ctrl_pkg.sv
// ============================================================================
// rv_ctrl_pkg: shared encodings for the multi-cycle RV32I control path.
// Rev 1.0
// ============================================================================
`default_nettype none

package rv_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0011;
  localparam logic [3:0] ALU_SLTU = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b1000;
  localparam logic [3:0] ALU_AND  = 4'b1001;

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_EX_R    = 4'd2;
  localparam logic [3:0] S_EX_I    = 4'd3;
  localparam logic [3:0] S_EX_ADDR = 4'd4;
  localparam logic [3:0] S_MEM_LD  = 4'd5;
  localparam logic [3:0] S_MEM_ST  = 4'd6;
  localparam logic [3:0] S_EX_BR   = 4'd7;
  localparam logic [3:0] S_EX_JAL  = 4'd8;
  localparam logic [3:0] S_EX_LUI  = 4'd9;
  localparam logic [3:0] S_WB_ALU  = 4'd10;
  localparam logic [3:0] S_WB_MEM  = 4'd11;

  localparam logic [1:0] SRC_A_PC     = 2'd0;
  localparam logic [1:0] SRC_A_RS1    = 2'd1;
  localparam logic [1:0] SRC_A_OLD_PC = 2'd2;
  localparam logic [1:0] SRC_A_ZERO   = 2'd3;

  localparam logic [1:0] SRC_B_RS2    = 2'd0;
  localparam logic [1:0] SRC_B_FOUR   = 2'd1;
  localparam logic [1:0] SRC_B_IMM    = 2'd2;

  localparam logic [1:0] WB_ALUOUT    = 2'd0;
  localparam logic [1:0] WB_MDR       = 2'd1;
  localparam logic [1:0] WB_PC        = 2'd2;

endpackage

`default_nettype wire

// File: rtl/alu_op_decoder.sv
// ============================================================================
// alu_op_decoder: funct3/funct7 to ALU opcode for OP and OP-IMM instructions.
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_op_decoder
  import rv_ctrl_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       is_imm,
  output logic [3:0] alu_control,
  output logic       illegal
);

  logic f7_zero;
  logic f7_alt;

  assign f7_zero = (funct7 == 7'h00);
  assign f7_alt  = (funct7 == 7'h20);

  // For OP-IMM, funct7 is immediate bits except on shifts, so it only matters there.
  always_comb begin
    alu_control = ALU_ADD;
    illegal     = 1'b0;
    case (funct3)
      3'b000: begin
        alu_control = (!is_imm && f7_alt) ? ALU_SUB : ALU_ADD;
        illegal     = !is_imm && !(f7_zero || f7_alt);
      end
      3'b001: begin
        alu_control = ALU_SLL;
        illegal     = !f7_zero;
      end
      3'b101: begin
        alu_control = f7_alt ? ALU_SRA : ALU_SRL;
        illegal     = !(f7_zero || f7_alt);
      end
      default: begin
        case (funct3)
          3'b010:  alu_control = ALU_SLT;
          3'b011:  alu_control = ALU_SLTU;
          3'b100:  alu_control = ALU_XOR;
          3'b110:  alu_control = ALU_OR;
          default: alu_control = ALU_AND;
        endcase
        illegal = !is_imm && !f7_zero;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_control.sv
// ============================================================================
// multicycle_control: FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer for RV32I.
// Rev 1.0
// ============================================================================
`default_nettype none

module multicycle_control
  import rv_ctrl_pkg::*;
#(
  parameter logic [3:0] RESET_STATE = S_FETCH
)(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        alu_zero,
  input  logic        mem_ready,
  output logic [3:0]  alu_control,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        pc_write,
  output logic        pc_src,
  output logic        ir_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_addr_sel,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic        illegal_instr,
  output logic        instr_retired
);

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic [3:0] dec_alu;
  logic       dec_illegal;
  logic [6:0] opcode;
  logic [2:0] funct3;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];

  alu_op_decoder u_alu_op_decoder (
    .funct3      (funct3),
    .funct7      (instr[31:25]),
    .is_imm      (state_q == S_EX_I),
    .alu_control (dec_alu),
    .illegal     (dec_illegal)
  );

  always_comb begin
    state_d       = state_q;
    alu_control   = ALU_ADD;
    alu_src_a     = SRC_A_PC;
    alu_src_b     = SRC_B_RS2;
    pc_write      = 1'b0;
    pc_src        = 1'b0;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_addr_sel  = 1'b0;
    reg_write     = 1'b0;
    wb_sel        = WB_ALUOUT;
    illegal_instr = 1'b0;
    instr_retired = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRC_B_FOUR;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        // Precompute the branch/jump target into ALUOut.
        alu_src_a = SRC_A_OLD_PC;
        alu_src_b = SRC_B_IMM;
        case (opcode)
          OP_R:               state_d = S_EX_R;
          OP_IMM:             state_d = S_EX_I;
          OP_LOAD, OP_STORE:  state_d = S_EX_ADDR;
          OP_BRANCH:          state_d = S_EX_BR;
          OP_JAL:             state_d = S_EX_JAL;
          OP_LUI:             state_d = S_EX_LUI;
          default: begin
            illegal_instr = 1'b1;
            state_d       = S_FETCH;
          end
        endcase
      end
      S_EX_R, S_EX_I: begin
        alu_src_a     = SRC_A_RS1;
        alu_src_b     = (state_q == S_EX_I) ? SRC_B_IMM : SRC_B_RS2;
        alu_control   = dec_alu;
        illegal_instr = dec_illegal;
        state_d       = dec_illegal ? S_FETCH : S_WB_ALU;
      end
      S_EX_ADDR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        state_d   = (opcode == OP_LOAD) ? S_MEM_LD : S_MEM_ST;
      end
      S_MEM_LD: begin
        mem_read     = 1'b1;
        mem_addr_sel = 1'b1;
        if (mem_ready) state_d = S_WB_MEM;
      end
      S_MEM_ST: begin
        mem_write    = 1'b1;
        mem_addr_sel = 1'b1;
        if (mem_ready) begin
          instr_retired = 1'b1;
          state_d       = S_FETCH;
        end
      end
      S_EX_BR: begin
        alu_src_a   = SRC_A_RS1;
        alu_src_b   = SRC_B_RS2;
        alu_control = ALU_SUB;
        state_d     = S_FETCH;
        if (funct3 == 3'b000 || funct3 == 3'b001) begin
          instr_retired = 1'b1;
          if ((funct3 == 3'b000) == alu_zero) begin
            pc_write = 1'b1;
            pc_src   = 1'b1;
          end
        end else begin
          illegal_instr = 1'b1;
        end
      end
      S_EX_JAL: begin
        pc_write      = 1'b1;
        pc_src        = 1'b1;
        reg_write     = 1'b1;
        wb_sel        = WB_PC;
        instr_retired = 1'b1;
        state_d       = S_FETCH;
      end
      S_EX_LUI: begin
        alu_src_a = SRC_A_ZERO;
        alu_src_b = SRC_B_IMM;
        state_d   = S_WB_ALU;
      end
      S_WB_ALU, S_WB_MEM: begin
        reg_write     = 1'b1;
        wb_sel        = (state_q == S_WB_MEM) ? WB_MDR : WB_ALUOUT;
        instr_retired = 1'b1;
        state_d       = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    // Reset abandons any in-flight access without side effects.
    if (rst) begin
      pc_write      = 1'b0;
      ir_write      = 1'b0;
      mem_write     = 1'b0;
      reg_write     = 1'b0;
      illegal_instr = 1'b0;
      instr_retired = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= RESET_STATE;
    else     state_q <= state_d;
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ============================================================================
// tb_multicycle_control: per-cycle scoreboard of expected control vectors.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = 32'h0;
  logic        alu_zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic [3:0]  alu_control;
  logic [1:0]  alu_src_a, alu_src_b, wb_sel;
  logic        pc_write, pc_src, ir_write, mem_read, mem_write;
  logic        mem_addr_sel, reg_write, illegal_instr, instr_retired;

  multicycle_control dut (
    .clk(clk), .rst(rst), .instr(instr), .alu_zero(alu_zero), .mem_ready(mem_ready),
    .alu_control(alu_control), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .mem_read(mem_read),
    .mem_write(mem_write), .mem_addr_sel(mem_addr_sel), .reg_write(reg_write),
    .wb_sel(wb_sel), .illegal_instr(illegal_instr), .instr_retired(instr_retired)
  );

  always #5 clk = ~clk;

  // Vector layout: {alu[3:0], a[1:0], b[1:0], wb[1:0], flags[8:0]}
  localparam logic [8:0] F_PW = 9'h100, F_PS = 9'h080, F_IR = 9'h040, F_MR = 9'h020;
  localparam logic [8:0] F_MW = 9'h010, F_MA = 9'h008, F_RW = 9'h004, F_IL = 9'h002;
  localparam logic [8:0] F_RT = 9'h001;
  localparam logic [18:0] M_ALL = 19'h7FFFF;
  localparam logic [18:0] M_RST = {10'h0, F_PW | F_IR | F_MW | F_RW | F_IL | F_RT};
  localparam logic [18:0] M_NOALU = 19'h0FFFF;

  typedef struct {
    string       tag;
    logic        rst;
    logic [31:0] instr;
    logic        rdy;
    logic        zero;
    logic [18:0] exp;
    logic [18:0] mask;
  } item_t;

  item_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [18:0] ev(input logic [3:0] alu, input logic [1:0] a,
                                     input logic [1:0] b, input logic [1:0] wb,
                                     input logic [8:0] fl);
    return {alu, a, b, wb, fl};
  endfunction

  task automatic check_eq(input string tag, input logic [18:0] got, input logic [18:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input logic r, input logic [31:0] ins,
                      input logic rdy, input logic zero, input logic [18:0] exp,
                      input logic [18:0] mask);
    item_t it;
    it.tag = tag; it.rst = r; it.instr = ins; it.rdy = rdy; it.zero = zero;
    it.exp = exp; it.mask = mask;
    sb.push_back(it);
  endtask

  task automatic push_fetch(input string tag, input logic [31:0] ins, input logic zero);
    push({tag, "_fetch"}, 1'b0, ins, 1'b1, zero, ev(4'h0, 2'd0, 2'd1, 2'd0, F_PW | F_IR | F_MR), M_ALL);
    push({tag, "_decode"}, 1'b0, ins, 1'b1, zero, ev(4'h0, 2'd2, 2'd2, 2'd0, 9'h0), M_ALL);
  endtask

  logic [18:0] got;

  initial begin
    // Power-up reset with mem_ready asserted: strobes must stay low.
    push("rst0", 1'b1, 32'h0, 1'b1, 1'b0, 19'h0, M_RST);
    push("rst1", 1'b1, 32'h0, 1'b1, 1'b0, 19'h0, M_RST);
    push("fetch_after_rst", 1'b0, 32'h0, 1'b0, 1'b0, ev(4'h0, 2'd0, 2'd1, 2'd0, F_MR), M_ALL);

    // sub x3,x1,x2
    push_fetch("sub", 32'h402081B3, 1'b0);
    push("sub_ex", 1'b0, 32'h402081B3, 1'b1, 1'b0, ev(4'h1, 2'd1, 2'd0, 2'd0, 9'h0), M_ALL);
    push("sub_wb", 1'b0, 32'h402081B3, 1'b0, 1'b0, ev(4'h0, 2'd0, 2'd0, 2'd0, F_RW | F_RT), M_ALL);

    // srai / srli
    push_fetch("srai", 32'h4032D293, 1'b0);
    push("srai_ex", 1'b0, 32'h4032D293, 1'b0, 1'b0, ev(4'h7, 2'd1, 2'd2, 2'd0, 9'h0), M_ALL);
    push("srai_wb", 1'b0, 32'h4032D293, 1'b0, 1'b0, ev(4'h0, 2'd0, 2'd0, 2'd0, F_RW | F_RT), M_ALL);
    push_fetch("srli", 32'h0032D293, 1'b0);
    push("srli_ex", 1'b0, 32'h0032D293, 1'b0, 1'b0, ev(4'h6, 2'd1, 2'd2, 2'd0, 9'h0), M_ALL);
    push("srli_wb", 1'b0, 32'h0032D293, 1'b0, 1'b0, ev(4'h0, 2'd0, 2'd0, 2'd0, F_RW | F_RT), M_ALL);

    // lw x4,8(x1) with two stall cycles in MEM_LD
    push_fetch("lw", 32'h0080A203, 1'b0);
    push("lw_addr", 1'b0, 32'h0080A203, 1'b1, 1'b0, ev(4'h0, 2'd1, 2'd2, 2'd0, 9'h0), M_ALL);
    for (int i = 0; i < 2; i++)
      push("lw_stall", 1'b0, 32'h0080A203, 1'b0, 1'b0, ev(4'h0, 2'd0, 2'd0, 2'd0, F_MR | F_MA), M_ALL);
    push("lw_mem", 1'b0, 32'h0080A203, 1'b1, 1'b0, ev(4'h0, 2'd0, 2'd0, 2'd0, F_MR | F_MA), M_ALL);
    push("lw_wb", 1'b0, 32'h0080A203, 1'b1, 1'b0, ev(4'h0, 2'd0, 2'd0, 2'd1, F_RW | F_RT), M_ALL);

    // beq / bne, taken and not taken
    push_fetch("beq_t", 32'h00208463, 1'b1);
    push("beq_t_ex", 1'b0, 32'h00208463, 1'b0, 1'b1, ev(4'h1, 2'd1, 2'd0, 2'd0, F_PW | F_PS | F_RT), M_ALL);
    push_fetch("beq_n", 32'h00208463, 1'b0);
    push("beq_n_ex", 1'b0, 32'h00208463, 1'b0, 1'b0, ev(4'h1, 2'd1, 2'd0, 2'd0, F_RT), M_ALL);
    push_fetch("bne_t", 32'h00209463, 1'b0);
    push("bne_t_ex", 1'b0, 32'h00209463, 1'b0, 1'b0, ev(4'h1, 2'd1, 2'd0, 2'd0, F_PW | F_PS | F_RT), M_ALL);
    push_fetch("bne_n", 32'h00209463, 1'b1);
    push("bne_n_ex", 1'b0, 32'h00209463, 1'b0, 1'b1, ev(4'h1, 2'd1, 2'd0, 2'd0, F_RT), M_ALL);

    // Illegal opcode, then illegal funct7 on an R-type
    push("ill_fetch", 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, ev(4'h0, 2'd0, 2'd1, 2'd0, F_PW | F_IR | F_MR), M_ALL);
    push("ill_decode", 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, ev(4'h0, 2'd2, 2'd2, 2'd0, F_IL), M_ALL);
    push_fetch("mul", 32'h022081B3, 1'b0);
    push("mul_ex", 1'b0, 32'h022081B3, 1'b0, 1'b0, ev(4'h0, 2'd1, 2'd0, 2'd0, F_IL), M_NOALU);

    // jal x1,0 and lui
    push_fetch("jal", 32'h000000EF, 1'b0);
    push("jal_ex", 1'b0, 32'h000000EF, 1'b0, 1'b0, ev(4'h0, 2'd0, 2'd0, 2'd2, F_PW | F_PS | F_RW | F_RT), M_ALL);
    push_fetch("lui", 32'h12345237, 1'b0);
    push("lui_ex", 1'b0, 32'h12345237, 1'b0, 1'b0, ev(4'h0, 2'd3, 2'd2, 2'd0, 9'h0), M_ALL);
    push("lui_wb", 1'b0, 32'h12345237, 1'b0, 1'b0, ev(4'h0, 2'd0, 2'd0, 2'd0, F_RW | F_RT), M_ALL);

    // sw x2,4(x1) interrupted by a 3-cycle reset while waiting in MEM_ST
    push_fetch("sw_rst", 32'h0020A223, 1'b0);
    push("sw_rst_addr", 1'b0, 32'h0020A223, 1'b0, 1'b0, ev(4'h0, 2'd1, 2'd2, 2'd0, 9'h0), M_ALL);
    push("sw_rst_wait", 1'b0, 32'h0020A223, 1'b0, 1'b0, ev(4'h0, 2'd0, 2'd0, 2'd0, F_MW | F_MA), M_ALL);
    push("sw_rst_hold0", 1'b1, 32'h0020A223, 1'b1, 1'b0, 19'h0, M_RST);
    push("sw_rst_hold1", 1'b1, 32'h0020A223, 1'b1, 1'b0, 19'h0, M_RST);
    push("sw_rst_hold2", 1'b1, 32'h0020A223, 1'b1, 1'b0, 19'h0, M_RST);
    push("sw_rst_fetch", 1'b0, 32'h0020A223, 1'b0, 1'b0, ev(4'h0, 2'd0, 2'd1, 2'd0, F_MR), M_ALL);

    // Zero-wait sw
    push_fetch("sw", 32'h0020A223, 1'b0);
    push("sw_addr", 1'b0, 32'h0020A223, 1'b0, 1'b0, ev(4'h0, 2'd1, 2'd2, 2'd0, 9'h0), M_ALL);
    push("sw_mem", 1'b0, 32'h0020A223, 1'b1, 1'b0, ev(4'h0, 2'd0, 2'd0, 2'd0, F_MW | F_MA | F_RT), M_ALL);
    push("end_fetch", 1'b0, 32'h0, 1'b0, 1'b0, ev(4'h0, 2'd0, 2'd1, 2'd0, F_MR), M_ALL);

    while (sb.size() > 0) begin
      item_t it;
      it = sb.pop_front();
      @(posedge clk);
      #1;
      rst = it.rst; instr = it.instr; mem_ready = it.rdy; alu_zero = it.zero;
      @(negedge clk);
      got = {alu_control, alu_src_a, alu_src_b, wb_sel, pc_write, pc_src, ir_write,
             mem_read, mem_write, mem_addr_sel, reg_write, illegal_instr, instr_retired};
      check_eq(it.tag, got & it.mask, it.exp & it.mask);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
